// File: rtl/hilo_unit.sv
// HI/LO register unit: launches MULT/MULTU operands to an external combinational multiplier,
// waits a fixed settle window, applies the unsigned correction and commits to HI/LO.
module hilo_unit #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        is_u_q, is_u_d;
  logic        done_q, done_d;
  logic [63:0] prod;

  // The multiplier is signed; for MULTU, each operand with bit 31 set was read as
  // (x - 2^32), so add the other operand shifted up by 32 to restore the unsigned product.
  always_comb begin
    prod = mul_z;
    if (is_u_q) begin
      if (mul_a_q[31]) prod = prod + {mul_b_q, 32'h0};
      if (mul_b_q[31]) prod = prod + {mul_a_q, 32'h0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    is_u_d  = is_u_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              mul_a_d = rs_data;
              mul_b_d = rt_data;
              is_u_d  = (op == OP_MULTU);
              cnt_d   = CNT_INIT;
              state_d = WAIT;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          {hi_d, lo_d} = prod;
          state_d      = IDLE;
          done_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      mul_a_q <= 32'h0;
      mul_b_q <= 32'h0;
      is_u_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      is_u_q  <= is_u_d;
      done_q  <= done_d;
    end
  end

  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign stall   = busy & ((op_valid & (op != OP_NONE)) | rd_hi | rd_lo);
  assign rd_data = rd_hi ? hi_q : (rd_lo ? lo_q : 32'h0);

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: a vector table of ops with hand-computed HI/LO results,
// followed by hand-written stall, read-bypass and reset-in-flight sequences.
module tb_hilo_unit;

  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_z;
  logic        rd_hi, rd_lo;
  logic [31:0] rd_data, hi, lo;
  logic        busy, stall, done;

  int checks = 0;
  int errors = 0;

  hilo_unit #(.LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mul_a(mul_a), .mul_b(mul_b),
    .mul_z(mul_z), .rd_hi(rd_hi), .rd_lo(rd_lo), .rd_data(rd_data),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  // Signed combinational multiplier in front of the unit.
  logic signed [63:0] sa, sb;
  assign sa    = {{32{mul_a[31]}}, mul_a};
  assign sb    = {{32{mul_b[31]}}, mul_b};
  assign mul_z = sa * sb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    bit is_mul;
    is_mul = (v.op == 3'b001) || (v.op == 3'b010);
    op_valid = 1'b1; op = v.op; rs_data = v.rs; rt_data = v.rt;
    #1;
    check("idle_stall", stall, 0);
    step();
    op_valid = 1'b0; op = 3'b000;
    if (is_mul) begin
      check("mul_a", mul_a, v.rs);
      check("mul_b", mul_b, v.rt);
      for (int i = 0; i < LATENCY; i++) begin
        check("busy_wait", busy, 1);
        check("done_wait", done, 0);
        step();
      end
      check("done_pulse", done, 1);
    end
    check("busy_after", busy, 0);
    check("hi", hi, v.hi);
    check("lo", lo, v.lo);
    rd_hi = 1'b1; #1;
    check("rd_hi", rd_data, v.hi);
    rd_lo = 1'b1; #1;
    check("rd_both_hi_wins", rd_data, v.hi);
    rd_hi = 1'b0; #1;
    check("rd_lo", rd_data, v.lo);
    rd_lo = 1'b0; #1;
    check("rd_none", rd_data, 0);
    step();
    check("done_one_cycle", done, 0);
  endtask

  int stall_cycles;

  initial begin
    vecs[0] = '{3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{3'b011, 32'h12345678, 32'h0,        32'h12345678, 32'h00000001};
    vecs[4] = '{3'b100, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0};
    vecs[5] = '{3'b010, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[6] = '{3'b001, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
    vecs[7] = '{3'b010, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[8] = '{3'b101, 32'hCAFEF00D, 32'h0,        32'h00000001, 32'h23456780};
    vecs[9] = '{3'b010, 32'h00000003, 32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFA};

    reset = 1'b1; op_valid = 1'b0; op = 3'b000; rs_data = 0; rt_data = 0;
    rd_hi = 1'b0; rd_lo = 1'b0;
    step(); step();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // MFHI right behind a MULT: stalled until commit, then sees the new HI.
    op_valid = 1'b1; op = 3'b001; rs_data = 32'h00010000; rt_data = 32'h00030000;
    step();
    op_valid = 1'b0; op = 3'b000; rd_hi = 1'b1; #1;
    stall_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stall) break;
      stall_cycles++;
      step();
    end
    check("mfhi_stall_cycles", stall_cycles, LATENCY);
    check("mfhi_new_hi", rd_data, 32'h00000003);
    rd_hi = 1'b0;
    step();

    // MTHI with same-cycle MFHI reads the old HI.
    op_valid = 1'b1; op = 3'b011; rs_data = 32'hDEADBEEF; rd_hi = 1'b1; #1;
    check("mthi_bypass_old", rd_data, 32'h00000003);
    step();
    op_valid = 1'b0; op = 3'b000;
    check("mthi_next_new", rd_data, 32'hDEADBEEF);
    rd_hi = 1'b0;
    step();

    // MTLO presented while busy is stalled and does not touch LO.
    op_valid = 1'b1; op = 3'b001; rs_data = 32'h00000005; rt_data = 32'h00000006;
    step();
    op = 3'b100; rs_data = 32'h11111111; #1;
    for (int i = 0; i < LATENCY; i++) begin
      check("mtlo_busy_stall", stall, 1);
      check("mtlo_busy_lo", lo, 32'h00000000);
      step();
    end
    op_valid = 1'b0; op = 3'b000; #1;
    check("mtlo_commit_lo", lo, 32'h0000001E);
    check("mtlo_commit_hi", hi, 32'h00000000);
    check("mtlo_commit_done", done, 1);
    step();

    // Reset mid-WAIT: async clear, product discarded, no done.
    op_valid = 1'b1; op = 3'b011; rs_data = 32'hA5A5A5A5;
    step();
    op = 3'b001; rs_data = 32'h00000002; rt_data = 32'h00000003;
    step();
    op_valid = 1'b0; op = 3'b000;
    step();
    rd_hi = 1'b1; #1;
    check("pre_rst_stall", stall, 1);
    check("pre_rst_hi", hi, 32'hA5A5A5A5);
    #2 reset = 1'b1; #1;
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_stall", stall, 0);
    #2 reset = 1'b0;
    rd_hi = 1'b0;
    step();
    for (int i = 0; i < 2 * LATENCY; i++) begin
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_hi", hi, 0);
      check("post_rst_lo", lo, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
